kbd_keymap_decoder: RTL and testbench

//   Turns decoded PS/2 key events (make/break, E0-extended) into ASCII bytes
//   via an external synchronous keymap ROM. Tracks left/right shift separately,

---
 rtl/kbd_keymap_decoder_if.sv | 26 ++
 rtl/kbd_keymap_decoder.sv | 101 ++++++++++
 tb/tb_kbd_keymap_decoder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/kbd_keymap_decoder_if.sv
// rtl/kbd_keymap_decoder_if.sv - key event, keymap ROM and decoded output bundle
interface kbd_keymap_decoder_if #(
    parameter int LANG_W = 1
);
    logic                key_valid;
    logic [7:0]          key_code;
    logic                key_break;
    logic                key_ext;
    logic [LANG_W+8:0]   rom_addr;
    logic [7:0]          rom_data;
    logic [7:0]          ascii;
    logic                ascii_valid;
    logic                shift_active;
    logic                caps_lock;
    logic [LANG_W-1:0]   lang_sel;

    modport master (
        output key_valid, key_code, key_break, key_ext, rom_data,
        input  rom_addr, ascii, ascii_valid, shift_active, caps_lock, lang_sel
    );

    modport slave (
        input  key_valid, key_code, key_break, key_ext, rom_data,
        output rom_addr, ascii, ascii_valid, shift_active, caps_lock, lang_sel
    );
endinterface

// File: rtl/kbd_keymap_decoder.sv
// rtl/kbd_keymap_decoder.sv - PS/2 key events to ASCII via external keymap ROM
module kbd_keymap_decoder #(
    parameter int         NUM_LANGS   = 2,
    parameter int         ROM_LATENCY = 1,
    parameter logic [7:0] CAPS_CODE   = 8'h58,
    parameter logic [7:0] LANG_CODE   = 8'h0E,
    parameter logic [7:0] LSHIFT_CODE = 8'h12,
    parameter logic [7:0] RSHIFT_CODE = 8'h59,
    localparam int        LANG_W      = (NUM_LANGS > 1) ? $clog2(NUM_LANGS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    kbd_keymap_decoder_if.slave       bus
);
    logic              r_lshift, r_rshift, r_caps, r_caps_held, r_lang_held;
    logic              r_shift_active;
    logic [LANG_W-1:0] r_lang;
    logic [LANG_W+8:0] r_rom_addr;
    logic [ROM_LATENCY-1:0] r_pipe;
    logic [7:0]        r_ascii;
    logic              r_ascii_valid;

    logic              w_mod_evt, w_is_l, w_is_r, w_is_caps, w_is_lang, w_lookup;
    logic              w_lshift_nxt, w_rshift_nxt, w_caps_nxt, w_caps_held_nxt, w_lang_held_nxt;
    logic [LANG_W-1:0] w_lang_nxt;

    assign w_is_l    = (bus.key_code == LSHIFT_CODE);
    assign w_is_r    = (bus.key_code == RSHIFT_CODE);
    assign w_is_caps = (bus.key_code == CAPS_CODE);
    assign w_is_lang = (bus.key_code == LANG_CODE);
    assign w_mod_evt = bus.key_valid & ~bus.key_ext;
    assign w_lookup  = w_mod_evt & ~bus.key_break &
                       ~(w_is_l | w_is_r | w_is_caps | w_is_lang);

    always_comb begin
        w_lshift_nxt    = r_lshift;
        w_rshift_nxt    = r_rshift;
        w_caps_nxt      = r_caps;
        w_caps_held_nxt = r_caps_held;
        w_lang_nxt      = r_lang;
        w_lang_held_nxt = r_lang_held;
        if (w_mod_evt) begin
            if (w_is_l) w_lshift_nxt = ~bus.key_break;
            if (w_is_r) w_rshift_nxt = ~bus.key_break;
            // Held flags suppress typematic repeats of the toggle keys
            if (w_is_caps) begin
                if (bus.key_break) begin
                    w_caps_held_nxt = 1'b0;
                end else if (!r_caps_held) begin
                    w_caps_nxt      = ~r_caps;
                    w_caps_held_nxt = 1'b1;
                end
            end
            if (w_is_lang) begin
                if (bus.key_break) begin
                    w_lang_held_nxt = 1'b0;
                end else if (!r_lang_held) begin
                    w_lang_nxt      = (r_lang == LANG_W'(NUM_LANGS - 1)) ? '0 : r_lang + 1'b1;
                    w_lang_held_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lshift       <= 1'b0;
            r_rshift       <= 1'b0;
            r_caps         <= 1'b0;
            r_caps_held    <= 1'b0;
            r_lang         <= '0;
            r_lang_held    <= 1'b0;
            r_shift_active <= 1'b0;
            r_rom_addr     <= '0;
            r_pipe         <= '0;
            r_ascii        <= 8'h00;
            r_ascii_valid  <= 1'b0;
        end else begin
            r_lshift       <= w_lshift_nxt;
            r_rshift       <= w_rshift_nxt;
            r_caps         <= w_caps_nxt;
            r_caps_held    <= w_caps_held_nxt;
            r_lang         <= w_lang_nxt;
            r_lang_held    <= w_lang_held_nxt;
            r_shift_active <= (w_lshift_nxt | w_rshift_nxt) ^ w_caps_nxt;
            // Address uses the modifier state in effect before this event
            if (w_lookup) r_rom_addr <= {r_lang, r_shift_active, bus.key_code};
            r_pipe[0] <= w_lookup;
            for (int i = 1; i < ROM_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
            r_ascii_valid <= r_pipe[ROM_LATENCY-1] && (bus.rom_data != 8'h00);
            if (r_pipe[ROM_LATENCY-1] && (bus.rom_data != 8'h00)) r_ascii <= bus.rom_data;
        end
    end

    assign bus.rom_addr     = r_rom_addr;
    assign bus.ascii        = r_ascii;
    assign bus.ascii_valid  = r_ascii_valid;
    assign bus.shift_active = r_shift_active;
    assign bus.caps_lock    = r_caps;
    assign bus.lang_sel     = r_lang;
endmodule

// File: tb/tb_kbd_keymap_decoder.sv
// tb/tb_kbd_keymap_decoder.sv - directed self-checking bench for kbd_keymap_decoder
module tb_kbd_keymap_decoder;
    localparam int NL   = 3;
    localparam int LAT  = 2;
    localparam int LW   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] rom_q;

    kbd_keymap_decoder_if #(.LANG_W(LW)) bus ();

    kbd_keymap_decoder #(.NUM_LANGS(NL), .ROM_LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lut(input logic [10:0] a);
        case (a)
            11'h01C: lut = 8'h61;
            11'h032: lut = 8'h62;
            11'h021: lut = 8'h63;
            11'h11C: lut = 8'h41;
            11'h21C: lut = 8'hE4;
            default: lut = 8'h00;
        endcase
    endfunction

    // ROM_LATENCY=2: data valid one cycle after the registered address
    always_ff @(posedge clk) rom_q <= lut(bus.rom_addr);
    assign bus.rom_data = rom_q;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] c, input logic b, input logic e);
        bus.key_code  = c;
        bus.key_break = b;
        bus.key_ext   = e;
        bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_break = 1'b0;
        bus.key_ext   = 1'b0;
    endtask

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 8'h00;
        bus.key_break = 1'b0;
        bus.key_ext   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_ascii", 16'(bus.ascii), 16'h0);
        chk("rst_valid", 16'(bus.ascii_valid), 16'h0);
        chk("rst_shift", 16'(bus.shift_active), 16'h0);
        chk("rst_caps", 16'(bus.caps_lock), 16'h0);
        chk("rst_lang", 16'(bus.lang_sel), 16'h0);
        chk("rst_addr", 16'(bus.rom_addr), 16'h0);

        // Plain 'a' lookup: pulse exactly LAT+1 cycles after the event
        send(8'h1C, 1'b0, 1'b0);
        chk("t1_addr", 16'(bus.rom_addr), 16'h01C);
        chk("t1_v1", 16'(bus.ascii_valid), 16'h0);
        @(negedge clk);
        chk("t1_v2", 16'(bus.ascii_valid), 16'h0);
        @(negedge clk);
        chk("t1_v3", 16'(bus.ascii_valid), 16'h1);
        chk("t1_ascii", 16'(bus.ascii), 16'h61);
        @(negedge clk);
        chk("t1_v4", 16'(bus.ascii_valid), 16'h0);
        chk("t1_hold", 16'(bus.ascii), 16'h61);

        // Independent left/right shift
        send(8'h12, 1'b0, 1'b0);
        chk("t2_lsh", 16'(bus.shift_active), 16'h1);
        send(8'h59, 1'b0, 1'b0);
        send(8'h12, 1'b1, 1'b0);
        chk("t2_rsh_held", 16'(bus.shift_active), 16'h1);
        send(8'h1C, 1'b0, 1'b0);
        chk("t2_addr", 16'(bus.rom_addr), 16'h11C);
        @(negedge clk);
        @(negedge clk);
        chk("t2_valid", 16'(bus.ascii_valid), 16'h1);
        chk("t2_ascii", 16'(bus.ascii), 16'h41);
        send(8'h59, 1'b1, 1'b0);
        chk("t2_off", 16'(bus.shift_active), 16'h0);

        // Caps lock with typematic repeats
        send(8'h58, 1'b0, 1'b0);
        chk("t3_caps_on", 16'(bus.caps_lock), 16'h1);
        chk("t3_caps_shift", 16'(bus.shift_active), 16'h1);
        send(8'h58, 1'b0, 1'b0);
        send(8'h58, 1'b0, 1'b0);
        chk("t3_caps_rep", 16'(bus.caps_lock), 16'h1);
        send(8'h58, 1'b1, 1'b0);
        send(8'h58, 1'b0, 1'b0);
        chk("t3_caps_off", 16'(bus.caps_lock), 16'h0);
        send(8'h58, 1'b1, 1'b0);
        send(8'h58, 1'b0, 1'b0);
        send(8'h12, 1'b0, 1'b0);
        chk("t3_caps_xor", 16'(bus.shift_active), 16'h0);
        send(8'h12, 1'b1, 1'b0);
        chk("t3_caps_only", 16'(bus.shift_active), 16'h1);
        send(8'h58, 1'b1, 1'b0);
        send(8'h58, 1'b0, 1'b0);
        send(8'h58, 1'b1, 1'b0);
        chk("t3_end_caps", 16'(bus.caps_lock), 16'h0);
        chk("t3_end_shift", 16'(bus.shift_active), 16'h0);

        // Language cycling with wrap, and extended-key immunity
        send(8'h0E, 1'b0, 1'b0);
        chk("t4_lang1", 16'(bus.lang_sel), 16'h1);
        send(8'h0E, 1'b0, 1'b0);
        chk("t4_lang_rep", 16'(bus.lang_sel), 16'h1);
        send(8'h0E, 1'b1, 1'b0);
        send(8'h0E, 1'b0, 1'b0);
        send(8'h0E, 1'b1, 1'b0);
        chk("t4_lang2", 16'(bus.lang_sel), 16'h2);
        send(8'h0E, 1'b0, 1'b0);
        send(8'h0E, 1'b1, 1'b0);
        chk("t4_lang0", 16'(bus.lang_sel), 16'h0);
        send(8'h12, 1'b0, 1'b1);
        chk("t4_ext_shift", 16'(bus.shift_active), 16'h0);
        chk("t4_ext_addr", 16'(bus.rom_addr), 16'h11C);
        for (int i = 0; i < 3; i++) begin
            chk("t4_ext_nopulse", 16'(bus.ascii_valid), 16'h0);
            @(negedge clk);
        end
        send(8'h12, 1'b1, 1'b1);
        send(8'h0E, 1'b0, 1'b0);
        send(8'h0E, 1'b1, 1'b0);
        send(8'h1C, 1'b0, 1'b0);
        chk("t4_page1_addr", 16'(bus.rom_addr), 16'h21C);
        @(negedge clk);
        @(negedge clk);
        chk("t4_page1_ascii", 16'(bus.ascii), 16'hE4);
        send(8'h0E, 1'b0, 1'b0);
        send(8'h0E, 1'b1, 1'b0);
        send(8'h0E, 1'b0, 1'b0);
        send(8'h0E, 1'b1, 1'b0);
        chk("t4_back0", 16'(bus.lang_sel), 16'h0);

        // Back-to-back lookups, then a non-printable key
        bus.key_break = 1'b0;
        bus.key_ext   = 1'b0;
        bus.key_valid = 1'b1;
        bus.key_code  = 8'h1C;
        @(negedge clk);
        bus.key_code  = 8'h32;
        @(negedge clk);
        bus.key_code  = 8'h21;
        @(negedge clk);
        bus.key_valid = 1'b0;
        chk("t5_p1_v", 16'(bus.ascii_valid), 16'h1);
        chk("t5_p1_a", 16'(bus.ascii), 16'h61);
        @(negedge clk);
        chk("t5_p2_v", 16'(bus.ascii_valid), 16'h1);
        chk("t5_p2_a", 16'(bus.ascii), 16'h62);
        @(negedge clk);
        chk("t5_p3_v", 16'(bus.ascii_valid), 16'h1);
        chk("t5_p3_a", 16'(bus.ascii), 16'h63);
        @(negedge clk);
        chk("t5_end_v", 16'(bus.ascii_valid), 16'h0);
        send(8'h15, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("t5_np_v", 16'(bus.ascii_valid), 16'h0);
            @(negedge clk);
        end
        chk("t5_np_hold", 16'(bus.ascii), 16'h63);

        // Reset with a lookup in flight; also leave modifiers set beforehand
        send(8'h58, 1'b0, 1'b0);
        send(8'h0E, 1'b0, 1'b0);
        send(8'h1C, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_ascii", 16'(bus.ascii), 16'h0);
        chk("t6_valid", 16'(bus.ascii_valid), 16'h0);
        chk("t6_shift", 16'(bus.shift_active), 16'h0);
        chk("t6_caps", 16'(bus.caps_lock), 16'h0);
        chk("t6_lang", 16'(bus.lang_sel), 16'h0);
        chk("t6_addr", 16'(bus.rom_addr), 16'h0);
        @(negedge clk);
        chk("t6_nopulse", 16'(bus.ascii_valid), 16'h0);
        @(negedge clk);
        chk("t6_nopulse2", 16'(bus.ascii_valid), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
